// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register: issues sequential fetches under
// a credit limit, buffers in-order responses, and flushes on a taken-branch redirect.
module if_prefetch_queue #(
  parameter int                 DEPTH    = 4,
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [ADDR_W-1:0]            imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [DATA_W-1:0]            imem_rsp_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  input  logic                         id_ready,
  output logic                         id_valid,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [DATA_W-1:0]            id_instr,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              PW      = $clog2(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     drop;

  logic [CW:0]       credit_used;
  logic              has_credit;
  logic              req_fire;
  logic              rsp_take;
  logic              push;
  logic              pop;
  logic [CW-1:0]     inflight_nxt;

  // Queued plus in-flight fetches are capped at DEPTH so every response has a slot.
  assign credit_used    = {1'b0, count} + {1'b0, inflight};
  assign has_credit     = credit_used < {1'b0, DEPTH_C};

  assign imem_req_valid = reset && !redirect_valid && has_credit;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_take       = reset && imem_rsp_valid && (inflight != '0);
  assign push           = rsp_take && !redirect_valid && (drop == '0);

  assign id_valid       = reset && (count != '0);
  assign id_pc          = pc_mem[rd_ptr];
  assign id_instr       = instr_mem[rd_ptr];
  assign occupancy      = reset ? count : '0;
  assign pop            = id_valid && id_ready && !redirect_valid;

  assign inflight_nxt   = inflight + CW'(req_fire) - CW'(rsp_take);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the wrong path.
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= inflight_nxt;
      drop     <= inflight_nxt;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
      inflight <= inflight_nxt;
      if (rsp_take) begin
        if (drop != '0) drop   <= drop - CW'(1);
        else            rsp_pc <= rsp_pc + ADDR_W'(4);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!reset) push |-> (count != DEPTH_C));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized scoreboard bench for if_prefetch_queue: an ideal in-order imem plus a
// PC-stream model of what ID should see after each redirect/reset.
module tb_if_prefetch_queue;
  localparam int          DEPTH = 4;
  localparam int          OW    = $clog2(DEPTH + 1);
  localparam logic [31:0] RPC   = 32'h0;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          id_ready;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_instr;
  logic [OW-1:0] occupancy;

  if_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  pend_t       pending[$];   // requests accepted by the imem model, oldest first
  logic [31:0] exp_q[$];     // PCs ID should still receive, in order
  logic [31:0] exp_pc;
  logic [31:0] mon_e;
  int total = 0, bad = 0, cyc = 0, pops = 0;

  int lat_min = 1, lat_max = 1, p_rdy = 100, p_id = 100, p_redir = 0;
  bit toggle_rdy = 0, rst_now = 1, redir_pend2 = 0, redir_rsp_pop = 0, hit = 0;
  logic [31:0] redir_tgt = 32'h200;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    int live, stale, queued;
    logic exp_rv;
    @(negedge clk);
    cyc++;
    live = 0;
    stale = 0;
    foreach (pending[i]) if (pending[i].stale) stale++; else live++;
    queued = exp_q.size() - live;
    reset = !rst_now;
    if (!rst_now && pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pending[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    redirect_valid = 1'b0;
    redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
    if (!rst_now) begin
      if ($urandom_range(0, 99) < p_redir) redirect_valid = 1'b1;
      if (redir_pend2 && live >= 2) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        hit            = 1'b1;
      end
      if (redir_rsp_pop && imem_rsp_valid && queued > 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_tgt;
        hit            = 1'b1;
      end
    end
    imem_req_ready = toggle_rdy ? (cyc % 2 == 1) : ($urandom_range(0, 99) < p_rdy);
    id_ready       = $urandom_range(0, 99) < p_id;
    #1;
    exp_rv = reset && !redirect_valid && (exp_q.size() + stale < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, exp_pc);
    chk("occupancy", 32'(occupancy), reset ? 32'(queued) : 32'd0);
    chk("id_valid", 32'(id_valid), 32'(reset && queued != 0));
    #2;
    if (!reset) begin
      exp_q.delete();
      pending.delete();
      exp_pc = RPC;
    end else begin
      if (imem_rsp_valid && pending.size() > 0) void'(pending.pop_front());
      if (redirect_valid) begin
        exp_q.delete();
        foreach (pending[i]) pending[i].stale = 1'b1;
        exp_pc = redirect_pc;
      end else if (imem_req_valid && imem_req_ready) begin
        pending.push_back('{due: cyc + int'($urandom_range(lat_min, lat_max)),
                            addr: imem_req_addr, stale: 1'b0});
        exp_q.push_back(exp_pc);
        exp_pc += 32'd4;
      end
    end
  endtask

  // Monitor: every ID handshake must match the oldest expected PC.
  initial forever begin
    @(negedge clk);
    #2;
    if (reset && id_valid && id_ready && !redirect_valid) begin
      pops++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected cyc=%0d got_pc=%h want=none", cyc, id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("id_pc", id_pc, mon_e);
        chk("id_instr", id_instr, mem_word(mon_e));
      end
    end
  end

  initial begin
    int p0;
    reset = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    exp_pc = RPC;

    repeat (2) step();
    rst_now = 0;

    // streaming with a 1-cycle imem: one instruction per cycle once warm
    repeat (10) step();
    p0 = pops;
    repeat (30) step();
    chk("throughput", 32'(pops - p0), 32'd30);

    // ID stall fills the queue and throttles requests
    p_id = 0;
    repeat (10) step();
    chk("stall_occ", 32'(occupancy), 32'(DEPTH));
    chk("stall_req", 32'(imem_req_valid), 32'd0);
    p_id = 100;
    repeat (15) step();

    // alternating request acceptance
    toggle_rdy = 1;
    repeat (12) step();
    toggle_rdy = 0;

    // 3-cycle imem, redirect to 0x80 with two fetches outstanding
    lat_min = 3;
    lat_max = 3;
    repeat (3) step();
    hit = 0;
    redir_pend2 = 1;
    for (int i = 0; i < 20 && !hit; i++) step();
    redir_pend2 = 0;
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL redir_pend2_timeout got=none want=redirect");
    end
    @(posedge clk);
    #1;
    chk("redir_occ", 32'(occupancy), 32'd0);
    repeat (12) step();

    // redirect coinciding with a response and a pending pop
    lat_min = 1;
    lat_max = 2;
    hit = 0;
    redir_rsp_pop = 1;
    for (int i = 0; i < 30 && !hit; i++) step();
    redir_rsp_pop = 0;
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL redir_rsp_pop_timeout got=none want=redirect");
    end
    repeat (10) step();

    // randomized traffic
    for (int blk = 0; blk < 8; blk++) begin
      lat_min = 1;
      lat_max = $urandom_range(1, 4);
      p_rdy   = $urandom_range(30, 100);
      p_id    = $urandom_range(30, 100);
      p_redir = $urandom_range(0, 10);
      repeat (100) step();
    end

    // reset with a full queue
    lat_min = 1;
    lat_max = 1;
    p_rdy = 100;
    p_id = 0;
    p_redir = 0;
    repeat (10) step();
    chk("pre_rst_full", 32'(occupancy), 32'(DEPTH));
    rst_now = 1;
    step();
    rst_now = 0;
    step();
    chk("post_rst_occ", 32'(occupancy), 32'd0);
    chk("post_rst_idv", 32'(id_valid), 32'd0);
    chk("post_rst_req", 32'(imem_req_valid), 32'd1);
    chk("post_rst_addr", imem_req_addr, RPC);
    p_id = 100;
    repeat (30) step();

    // drain: nothing expected may be left undelivered
    p_rdy = 0;
    repeat (15) step();
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
Instruction prefetch buffer that sits directly upstream of the IF/ID pipeline register of the 5-stage RISC-V core. It generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel. In-order responses are buffered in a small FIFO and presented to the ID stage with their PCs. A taken branch from the MEM stage (EX_MEM_BranchTaken / target) flushes the queue and discards stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; also the cap on queued plus in-flight fetches (power of 2, >=2)
ADDR_W, 32, PC width
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low; reset==0 at a posedge initialises all state
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_req_addr  out  ADDR_W  fetch byte address
imem_rsp_valid  in  1  response valid; in order, >=1 cycle after acceptance
imem_rsp_data  in  DATA_W  fetched instruction
redirect_valid  in  1  taken branch from MEM stage
redirect_pc  in  ADDR_W  branch target
id_ready  in  1  ID stage consumes head entry (low = ID stall)
id_valid  out  1  head entry valid
id_pc  out  ADDR_W  head PC
id_instr  out  DATA_W  head instruction
occupancy  out  clog2(DEPTH+1)  entries currently queued

Behaviour:
- State: fetch_pc, FIFO (pc+instr, rd/wr pointers, count), inflight (accepted requests with no response yet), drop (oldest in-flight responses still to discard).
- Reset (reset==0 at posedge): fetch_pc=RESET_PC, count=0, inflight=0, drop=0, pointers=0. Outputs during and after reset cycle: id_valid=0, occupancy=0, imem_req_valid=0. The cycle after reset is released, imem_req_valid=1 with addr=RESET_PC. Reset mid-operation discards all queued and in-flight state. Responses to requests issued before reset are not tracked; the bench must not return them.
- Request: imem_req_valid = !redirect_valid && (count + inflight < DEPTH). imem_req_addr = fetch_pc. On valid&&ready: fetch_pc += 4 (wraps mod 2^ADDR_W), inflight += 1.
- Response: on imem_rsp_valid: inflight -= 1. If drop != 0, drop -= 1 and data is discarded. Otherwise push {pc, instr} into the FIFO tail. The tail PC comes from an internal response-PC register: loaded on redirect/reset, incremented by 4 per accepted response.
- Head: id_valid = (count != 0). id_pc/id_instr come from the head entry (first-word fall-through, combinational from registers). Pop occurs when id_valid && id_ready && !redirect_valid.
- Simultaneous push and pop: count unchanged, both pointers advance. Overflow is impossible by the credit rule; a push when count==DEPTH is a design error (assert in sim).
- Redirect (redirect_valid=1 at posedge): count=0, pointers reset, fetch_pc=redirect_pc, response-PC=redirect_pc. Any same-cycle response is discarded. drop = inflight after this cycle's response is accounted. No request is issued and no pop occurs in that cycle. Redirect wins over every simultaneous event.
- Redirect while drop != 0: drop is recomputed as above, so no stale response ever reaches the FIFO.
- Latency (1-cycle imem, ready=1): request at cycle T, response T+1, id_valid at T+2. After a redirect at cycle N: request for redirect_pc at N+1, id_valid with id_pc=redirect_pc at N+3.
- Throughput: with DEPTH>=4, 1-cycle imem, and id_ready=1, sustains 1 instruction/cycle.
- Arithmetic: count, inflight, and drop are clog2(DEPTH+1) bits and never exceed DEPTH. Pointers are clog2(DEPTH) bits with natural wrap.

Test Plan:
- Reset release, 1-cycle imem (mem[i]=0x1000+i), id_ready=1 -> id_pc 0,4,8,... with id_instr 0x1000,0x1001,...; first id_valid 2 cycles after the first request; then one entry per cycle.
- id_ready=0 for 10 cycles -> occupancy rises to 4, imem_req_valid drops once count+inflight=4. Raising id_ready resumes in-order delivery with no lost or duplicated PC.
- imem_req_ready toggled 1,0,1,0 -> imem_req_addr held while not accepted; delivered PCs stay strictly sequential.
- 3-cycle-latency imem, 2 requests in flight, redirect to 0x80 -> both late responses dropped. Next id_pc=0x80 with mem[0x20]; occupancy 0 the cycle after redirect.
- Redirect in the same cycle as imem_rsp_valid and a pending pop -> response discarded, no pop, drop = remaining inflight. Next delivered id_pc = target.
- reset=0 asserted mid-stream with queue full -> next cycle id_valid=0, occupancy=0. After release, first request addr=RESET_PC.
